mem_ctrl: RTL
=============

# mem_ctrl

Memory controller that arbitrates the load/store buffer's load and store ports and the instruction-fetch port onto the single byte-wide RAM/IO bus. It serialises each 1/2/4-byte access into one byte per cycle and reassembles or sign-extends read data. It returns a one-cycle `finish_load`/`finish_store`/`ifetch_done` pulse to the requester. It is the responder end of the LSB memory handshake and sits between `load_store_buffer`, the fetch unit and the RAM.

## Interface
- `IO_MASK_HI`, 2'b11, value of `addr[17:16]` that marks I/O space.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; asynchronous, active-high.
- `rdy_in`  in  1  pause when low.
- `roll_back`  in  1  misprediction flush.
- `lsb_load`, `load_address`[31:0], `op_type_load`[5:0]  in  load request level, address, op.
- `finish_load`  out  1  one-cycle completion pulse.
- `data_load`  out  32  extended load data, valid with `finish_load`.
- `lsb_store`, `store_address`[31:0], `data_store`[31:0], `op_type_store`[5:0]  in  store request.
- `finish_store`  out  1  one-cycle completion pulse.
- `ifetch_req`, `ifetch_addr`[31:0]  in  instruction word request.
- `ifetch_done`  out  1  pulse.
- `ifetch_data`  out  32  fetched word.
- `mem_din`  in  8  RAM read byte.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  write enable.
- `io_buffer_full`  in  1  UART output buffer full.

## Operation
- Ops use the shared op encoding: LB/LBU/SB=1 byte, LH/LHU/SH=2, LW/SW=4, fetch=4.
- States: IDLE, LOAD, STORE, FETCH, DONE. Byte counter `cnt`[2:0].
- In IDLE, requests are sampled with priority store > load > fetch. The chosen request's address, op and data are latched, then `cnt`=0.
- LOAD/FETCH: cycle k (k=0..N-1) drives `mem_a`=addr+k. Byte k is read from `mem_din` in cycle k+1 into bits [8k+7:8k]. After byte N-1 is captured, go to DONE.
- STORE: cycle k drives `mem_a`=addr+k, `mem_dout`=data[8k+7:8k], `mem_wr`=1. After byte N-1, go to DONE.
- DONE raises exactly one of `finish_load`/`finish_store`/`ifetch_done` for one cycle, then returns to IDLE.
  - Requests are not sampled on the edge leaving DONE, because the requester is still dropping its level.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW/fetch full word.
- Address arithmetic is 32-bit wrap-around; there is no alignment check.
- `roll_back` in LOAD/FETCH, or in DONE for a load/fetch: return to IDLE on the next edge, no pulse.
- STORE ignores `roll_back` (stores are committed) and completes normally.
- `rdy_in` low: state, counter and captured data hold. `mem_wr` is gated to 0 combinationally. The address is re-driven on resume, so the read byte is re-captured.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0.
- In IDLE, `mem_a`=0 and `mem_wr`=0.
- Load or fetch of N bytes: the pulse comes N+2 cycles after the acceptance edge (N address cycles, 1 capture cycle, DONE).
  - LW: `finish_load` in cycle 6 counted from acceptance edge = cycle 0.
- Store of N bytes: `finish_store` in cycle N+1.
- Minimum gap between back-to-back accesses: 1 idle cycle after DONE.
- Simultaneous store+load+fetch in IDLE: store served first, then load, then fetch. Each waits while its level stays high.
- Reset mid-access aborts immediately; a partial store is not completed.

## Configuration
- `MEM_CTRL_IO_STALL_EN` defined: a STORE byte whose address has `addr[17:16]`==`IO_MASK_HI` while `io_buffer_full`=1 holds `cnt`, drives `mem_wr`=0, and retries each cycle until the input is low.
- Not defined: `io_buffer_full` is ignored and I/O writes proceed at full rate.

## Test plan
- LB from 0x100, RAM byte 0x80 -> `finish_load` once, `data_load`=0xFFFFFF80. LBU same -> 0x00000080.
- SW 0x11223344 to 0x200 -> `mem_wr` 4 cycles with bytes 44,33,22,11 at 0x200..0x203, then a single `finish_store`.
- `lsb_store`, `lsb_load` and `ifetch_req` raised together -> store completes first, then the load, then the fetch (word 0x00000013 returned on `ifetch_data`).
- LW in progress, `roll_back` in cycle 2 -> no `finish_load`, IDLE next cycle, `mem_wr` never 1.
- SB to 0x30000 with `io_buffer_full`=1 for 5 cycles (macro defined) -> `mem_wr` stays 0 for those 5 cycles, the write happens after the input drops, then `finish_store`.
  - Macro undefined -> the write happens immediately.
- `rdy_in` low for 3 cycles mid-LH -> the result still equals the RAM halfword, and `mem_wr` stays 0 throughout.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LSB load/store and instruction-fetch accesses onto a
// byte-wide RAM/IO bus, one byte per cycle, and reassembles/extends read data.
// Op encoding: LB=11 LH=12 LW=13 LBU=14 LHU=15 SB=16 SH=17 SW=18.
// Optional feature macro: MEM_CTRL_IO_STALL_EN. When it is defined, a store byte
// aimed at I/O space waits while io_buffer_full is high.
module mem_ctrl #(
  parameter logic [1:0] IO_MASK_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        lsb_load,
  input  logic [31:0] load_address,
  input  logic [5:0]  op_type_load,
  output logic        finish_load,
  output logic [31:0] data_load,
  input  logic        lsb_store,
  input  logic [31:0] store_address,
  input  logic [31:0] data_store,
  input  logic [5:0]  op_type_store,
  output logic        finish_store,
  input  logic        ifetch_req,
  input  logic [31:0] ifetch_addr,
  output logic        ifetch_done,
  output logic [31:0] ifetch_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [5:0] OP_LB  = 6'd11;
  localparam logic [5:0] OP_LH  = 6'd12;
  localparam logic [5:0] OP_LW  = 6'd13;
  localparam logic [5:0] OP_LBU = 6'd14;
  localparam logic [5:0] OP_LHU = 6'd15;
  localparam logic [5:0] OP_SB  = 6'd16;
  localparam logic [5:0] OP_SH  = 6'd17;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_FETCH, S_DONE} state_t;
  typedef enum logic [1:0] {K_LOAD, K_STORE, K_FETCH} kind_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [5:0]  op_q;
  logic [2:0]  len_q;
  kind_t       kind_q;

  logic [31:0] byte_addr;
  logic [31:0] ext_data;
  logic        io_hold;
  logic        capture;
  logic [1:0]  cap_sel;

  // Number of bus bytes an op moves.
  function automatic logic [2:0] op_len(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
      default:              op_len = 3'd4;
    endcase
  endfunction

  assign byte_addr = addr_q + {29'd0, cnt_q};

  // A read byte for position cnt-1 sits on mem_din while cnt is 1..len.
  assign capture = rdy_in && !roll_back && (cnt_q != 3'd0) &&
                   ((state_q == S_LOAD) || (state_q == S_FETCH));
  assign cap_sel = cnt_q[1:0] - 2'd1;

`ifdef MEM_CTRL_IO_STALL_EN
  assign io_hold = (state_q == S_STORE) && (byte_addr[17:16] == IO_MASK_HI) &&
                   io_buffer_full;
`else
  logic unused_io;
  assign io_hold   = 1'b0;
  assign unused_io = ^{io_buffer_full, IO_MASK_HI};
`endif

  // State register and byte counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch and read-data assembly.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      op_q    <= 6'd0;
      len_q   <= 3'd0;
      kind_q  <= K_LOAD;
    end else if (rdy_in && (state_q == S_IDLE)) begin
      rdata_q <= 32'd0;
      if (lsb_store) begin
        addr_q  <= store_address;
        wdata_q <= data_store;
        op_q    <= op_type_store;
        len_q   <= op_len(op_type_store);
        kind_q  <= K_STORE;
      end else if (lsb_load) begin
        addr_q  <= load_address;
        op_q    <= op_type_load;
        len_q   <= op_len(op_type_load);
        kind_q  <= K_LOAD;
      end else if (ifetch_req) begin
        addr_q  <= ifetch_addr;
        op_q    <= OP_LW;
        len_q   <= 3'd4;
        kind_q  <= K_FETCH;
      end
    end else if (capture) begin
      rdata_q[{cap_sel, 3'b000} +: 8] <= mem_din;
    end
  end

  // Next-state: arbitration in IDLE, byte stepping, flush and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          cnt_d = 3'd0;
          if (lsb_store)       state_d = S_STORE;
          else if (lsb_load)   state_d = S_LOAD;
          else if (ifetch_req) state_d = S_FETCH;
        end
        S_LOAD, S_FETCH: begin
          if (roll_back) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end else if (cnt_q == len_q) begin
            state_d = S_DONE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_STORE: begin
          if (!io_hold) begin
            if (cnt_q == len_q - 3'd1) begin
              state_d = S_DONE;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Load extension from the captured bytes.
  always_comb begin
    case (op_q)
      OP_LB:   ext_data = {{24{rdata_q[7]}}, rdata_q[7:0]};
      OP_LBU:  ext_data = {24'd0, rdata_q[7:0]};
      OP_LH:   ext_data = {{16{rdata_q[15]}}, rdata_q[15:0]};
      OP_LHU:  ext_data = {16'd0, rdata_q[15:0]};
      default: ext_data = rdata_q;
    endcase
  end

  // Bus drive and completion pulses.
  always_comb begin
    mem_a        = 32'd0;
    mem_dout     = 8'd0;
    mem_wr       = 1'b0;
    finish_load  = 1'b0;
    finish_store = 1'b0;
    ifetch_done  = 1'b0;
    data_load    = 32'd0;
    ifetch_data  = 32'd0;
    case (state_q)
      S_LOAD, S_FETCH: begin
        // While paused, keep presenting the byte still owed so its data is
        // back on mem_din in the first cycle after running resumes.
        if (!rdy_in && (cnt_q != 3'd0)) mem_a = byte_addr - 32'd1;
        else if (cnt_q != len_q)         mem_a = byte_addr;
      end
      S_STORE: begin
        mem_a    = byte_addr;
        mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        mem_wr   = rdy_in && !io_hold;
      end
      S_DONE: begin
        if (rdy_in && !(roll_back && (kind_q != K_STORE))) begin
          case (kind_q)
            K_LOAD: begin
              finish_load = 1'b1;
              data_load   = ext_data;
            end
            K_STORE: finish_store = 1'b1;
            K_FETCH: begin
              ifetch_done = 1'b1;
              ifetch_data = rdata_q;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule
